bitstream_receiver: RTL and testbench
=====================================

Name: bitstream_receiver

Overview:
- Receive-side counterpart of the 32-bit serial shift-register link: serial data, shift clock, latch clock and shift-register reset.
- Oversamples all four link lines in the local clock domain and rebuilds each 32-bit word as {data_high, data_low}.
- Presents the word on a valid/ready interface, with word/bit counters and sticky error flags.
- Used as an in-FPGA shift-register model for loopback verification and as the link endpoint on a receiving board.

Parameters:
- WORD_BITS, 32, bits per word; fixed split into two 16-bit halves; other values unsupported.
- SYNC_STAGES, 2, flops per link-input synchronizer; legal values 2..4.

Ports:
- clock  in  1  local sampling clock; must be at least 4x the link shift_clock rate.
- reset_n  in  1  asynchronous, active-low reset.
- bitstream_in  in  1  serial data, asynchronous to clock.
- shift_clock_in  in  1  link shift clock; data sampled on its rising edge.
- latch_clock_in  in  1  link latch; rising edge transfers the word.
- shift_reg_reset_in  in  1  link shift-register reset; rising edge clears the assembly register.
- word_ready  in  1  consumer accepts the word.
- clear_errors  in  1  single-cycle pulse; clears the sticky error flags.
- word_valid  out  1  word held on data_low/data_high.
- data_low  out  16  received bits 0..15.
- data_high  out  16  received bits 16..31.
- bit_count  out  6  number of shifts captured with the presented word (0..32).
- word_count  out  16  accepted-word counter; wraps 65535->0.
- err_short  out  1  sticky; a latch arrived with fewer than 32 bits.
- err_overrun  out  1  sticky; shift edge seen in FULL or LATCHED.
- err_overflow  out  1  sticky; a latch arrived while word_valid was high and unaccepted.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, synchronizer chains 0, assembly register 0, state EMPTY.
- Input conditioning:
  - Each link line goes through a SYNC_STAGES synchronizer plus one edge-detect flop.
  - Edge events are single-cycle strobes.
  - Each input level must be held at least 2 clock cycles; shorter pulses are unsupported.
- Bit ordering:
  - Shift event: shreg <= {data_bit, shreg[31:1]}, with data_bit taken from the synchronizer stage aligned with the shift clock.
  - After 32 shifts, the n-th received bit (n=0 first) sits at word position n.
  - Bits 0..15 go to data_low, bits 16..31 to data_high.
- cnt: 6-bit shift counter, saturates at 32.
- FSM states:
  - EMPTY: cnt=0. Shift event -> SHIFTING, cnt=1.
  - SHIFTING: each shift event increments cnt. Reaching cnt=32 -> FULL.
  - FULL: further shift events keep shifting (oldest bit lost), cnt stays 32, err_overrun set.
  - LATCHED: entered from any state on a latch event. A shift event here behaves as in FULL: shifts, cnt saturates, err_overrun set. Shift-reset event -> EMPTY.
  - Any state: shift-reset event -> shreg=0, cnt=0, EMPTY.
- Latch event:
  - If word_valid=0: data_* <= shreg, bit_count <= cnt, word_valid <= 1 on the following cycle.
  - If word_valid=1 and word_ready=0: the new word is dropped, presented data is unchanged, err_overflow set.
  - If cnt<32: err_short set; the word is still delivered.
  - Latch does not clear shreg or cnt.
- Handshake:
  - Transfer occurs when word_valid and word_ready are both high.
  - On transfer: word_valid clears next cycle and word_count increments.
  - Latch in the same cycle as a transfer: the new word is loaded, word_valid stays 1, no overflow.
- Latency:
  - Link edge to internal strobe: SYNC_STAGES+1 cycles.
  - Latch strobe to word_valid: 1 cycle.
- Simultaneous strobes in one cycle:
  - shift+latch: shift applied first; the latched word includes the new bit.
  - latch+reset: latch captures the pre-reset content, then the clear is applied.
  - shift+reset: reset wins; the bit is discarded.
- clear_errors: clears the three error flags; an error event in the same cycle wins (flag stays set).
- Mid-word reset_n assertion: immediate clear; the partial word is lost; no word_valid is produced.

Decomposition:
- Shared package bitstream_link_pkg holds:
  - WORD_BITS and HALF_BITS=16.
  - Link state enum {EMPTY, SHIFTING, FULL, LATCHED}.
  - Bit-count width localparam.
- The transmitter's latch/reset timing constants go in the same package.
- One sub-module: link_sync_edge (SYNC_STAGES synchronizer plus rising-edge strobe), instantiated three times for shift, latch and reset.
- The data line uses a plain synchronizer with matched depth.

Test Plan:
- Shift 32 bits of 0xA5C3_0F81 (bit 0 first), then latch -> data_low=0x0F81, data_high=0xA5C3, bit_count=32, word_valid=1, no errors; word_ready pulse -> word_count=1.
- Shift 20 bits, then latch -> err_short=1, bit_count=20, delivered word carries the 20 bits in positions 12..31; clear_errors -> err_short=0.
- Shift 34 bits of an incrementing pattern, then latch -> err_overrun=1, bit_count=32, word equals the last 32 bits received.
- word_ready held 0 over two latched words -> first word retained, err_overflow=1; release word_ready -> one transfer, word_count=1.
- Latch and shift-reset on the same sampled cycle after 32 bits -> word delivered intact, state EMPTY; then 1 shift + latch -> bit_count=1.
- Assert reset_n low mid-word (after 10 bits) -> all outputs 0 within the same cycle; after release, a 32-bit word is received correctly.

Source files
------------

// File: rtl/bitstream_link_pkg.sv
// Shared definitions for the 32-bit serial shift-register link: word geometry,
// receiver state encoding and transmitter pulse timing.
package bitstream_link_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned HALF_BITS = 16;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        StEmpty,
        StShifting,
        StFull,
        StLatched
    } link_state_e;

    // Transmitter timing in local clock cycles; each level is held >= 2 cycles.
    localparam int unsigned TX_SHIFT_HALF_CYCLES = 4;
    localparam int unsigned TX_LATCH_HIGH_CYCLES = 4;
    localparam int unsigned TX_RESET_HIGH_CYCLES = 4;

endpackage

// File: rtl/link_sync_edge.sv
// Multi-flop synchronizer for one asynchronous link line followed by a
// rising-edge detector producing a single-cycle strobe.
module link_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/bitstream_receiver.sv
// Receive endpoint of the serial shift-register link: oversamples the link lines,
// rebuilds 32-bit words and presents them on a valid/ready interface.
module bitstream_receiver #(
    parameter int unsigned WORD_BITS   = bitstream_link_pkg::WORD_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bitstream_in,
    input  logic        shift_clock_in,
    input  logic        latch_clock_in,
    input  logic        shift_reg_reset_in,
    input  logic        word_ready,
    input  logic        clear_errors,
    output logic        word_valid,
    output logic [15:0] data_low,
    output logic [15:0] data_high,
    output logic [5:0]  bit_count,
    output logic [15:0] word_count,
    output logic        err_short,
    output logic        err_overrun,
    output logic        err_overflow
);
    import bitstream_link_pkg::*;

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(WORD_BITS);

    logic shift_rise, latch_rise, reset_rise;

    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_shift_sync (
        .clk_i (clock), .rst_ni(reset_n), .line_i(shift_clock_in), .rise_o(shift_rise)
    );
    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_i (clock), .rst_ni(reset_n), .line_i(latch_clock_in), .rise_o(latch_rise)
    );
    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
        .clk_i (clock), .rst_ni(reset_n), .line_i(shift_reg_reset_in), .rise_o(reset_rise)
    );

    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    link_state_e            state_q, state_d, state_sh;
    logic [WORD_BITS-1:0]   shreg_q, shreg_d, shreg_sh;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_sh;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic [CNT_W-1:0]       bit_count_q, bit_count_d;
    logic                   word_valid_q, word_valid_d;
    logic [15:0]            word_count_q, word_count_d;
    logic                   err_short_q, err_short_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   err_overflow_q, err_overflow_d;
    logic                   shift_ev, transfer, short_ev, overrun_ev, overflow_ev;

    always_comb begin
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bitstream_in};

        // A shift-register reset in the same cycle discards the shift.
        shift_ev = shift_rise & ~reset_rise;
        shreg_sh = shreg_q;
        cnt_sh   = cnt_q;
        state_sh = state_q;
        if (shift_ev) begin
            shreg_sh = {data_sync_q[SYNC_STAGES-1], shreg_q[WORD_BITS-1:1]};
            if (cnt_q != CntFull) cnt_sh = cnt_q + CNT_W'(1);
            unique case (state_q)
                StEmpty, StShifting: state_sh = (cnt_sh == CntFull) ? StFull : StShifting;
                default:             state_sh = state_q;
            endcase
        end
        overrun_ev = shift_ev && (state_q == StFull || state_q == StLatched);

        transfer     = word_valid_q & word_ready;
        word_valid_d = word_valid_q & ~transfer;
        word_count_d = word_count_q + {15'd0, transfer};
        word_d       = word_q;
        bit_count_d  = bit_count_q;
        short_ev     = 1'b0;
        overflow_ev  = 1'b0;

        // Latch sees the post-shift content, so a coincident shift is included.
        if (latch_rise) begin
            state_sh = StLatched;
            short_ev = (cnt_sh != CntFull);
            if (!word_valid_q || transfer) begin
                word_d       = shreg_sh;
                bit_count_d  = cnt_sh;
                word_valid_d = 1'b1;
            end else begin
                overflow_ev = 1'b1;
            end
        end

        shreg_d = shreg_sh;
        cnt_d   = cnt_sh;
        state_d = state_sh;
        if (reset_rise) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = StEmpty;
        end

        err_short_d    = (err_short_q    & ~clear_errors) | short_ev;
        err_overrun_d  = (err_overrun_q  & ~clear_errors) | overrun_ev;
        err_overflow_d = (err_overflow_q & ~clear_errors) | overflow_ev;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_sync_q    <= '0;
            state_q        <= StEmpty;
            shreg_q        <= '0;
            cnt_q          <= '0;
            word_q         <= '0;
            bit_count_q    <= '0;
            word_valid_q   <= 1'b0;
            word_count_q   <= '0;
            err_short_q    <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            data_sync_q    <= data_sync_d;
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            bit_count_q    <= bit_count_d;
            word_valid_q   <= word_valid_d;
            word_count_q   <= word_count_d;
            err_short_q    <= err_short_d;
            err_overrun_q  <= err_overrun_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign data_low     = word_q[HALF_BITS-1:0];
    assign data_high    = word_q[WORD_BITS-1:HALF_BITS];
    assign bit_count    = bit_count_q;
    assign word_count   = word_count_q;
    assign err_short    = err_short_q;
    assign err_overrun  = err_overrun_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_bitstream_receiver.sv
// Directed bench for bitstream_receiver: a vector table of whole words plus
// hand-written sequences for overflow, coincident strobes and mid-word reset.
module tb_bitstream_receiver;
    import bitstream_link_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        bitstream_in, shift_clock_in, latch_clock_in, shift_reg_reset_in;
    logic        word_ready, clear_errors;
    logic        word_valid;
    logic [15:0] data_low, data_high, word_count;
    logic [5:0]  bit_count;
    logic        err_short, err_overrun, err_overflow;

    int checks   = 0;
    int failures = 0;
    int exp_wc   = 0;

    bitstream_receiver #(.WORD_BITS(32), .SYNC_STAGES(2)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .bitstream_in      (bitstream_in),
        .shift_clock_in    (shift_clock_in),
        .latch_clock_in    (latch_clock_in),
        .shift_reg_reset_in(shift_reg_reset_in),
        .word_ready        (word_ready),
        .clear_errors      (clear_errors),
        .word_valid        (word_valid),
        .data_low          (data_low),
        .data_high         (data_high),
        .bit_count         (bit_count),
        .word_count        (word_count),
        .err_short         (err_short),
        .err_overrun       (err_overrun),
        .err_overflow      (err_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        logic [15:0] exp_low;
        logic [15:0] exp_high;
        logic [5:0]  exp_cnt;
        logic        exp_short;
        logic        exp_overrun;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bitstream_in = b;
        tick(TX_SHIFT_HALF_CYCLES);
        shift_clock_in = 1'b1;
        tick(TX_SHIFT_HALF_CYCLES);
        shift_clock_in = 1'b0;
    endtask

    task automatic shift_word(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) shift_bit(bits[i]);
        tick(TX_SHIFT_HALF_CYCLES);
    endtask

    task automatic latch_pulse();
        latch_clock_in = 1'b1;
        tick(TX_LATCH_HIGH_CYCLES);
        latch_clock_in = 1'b0;
        tick(TX_LATCH_HIGH_CYCLES);
    endtask

    task automatic sreg_reset_pulse();
        shift_reg_reset_in = 1'b1;
        tick(TX_RESET_HIGH_CYCLES);
        shift_reg_reset_in = 1'b0;
        tick(TX_RESET_HIGH_CYCLES);
    endtask

    task automatic ready_pulse();
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    task automatic accept_word(input string tag);
        ready_pulse();
        exp_wc++;
        check({tag, "_valid_after_ready"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_word_count"}, {16'd0, word_count}, exp_wc);
    endtask

    initial begin
        vecs[0] = '{64'h0000_0000_A5C3_0F81, 32, 16'h0F81, 16'hA5C3, 6'd32, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0000_000A_BCDE, 20, 16'hE000, 16'hABCD, 6'd20, 1'b1, 1'b0};
        vecs[2] = '{64'h0000_0001_D950_C843, 34, 16'h3210, 16'h7654, 6'd32, 1'b0, 1'b1};

        reset_n = 1'b0;
        bitstream_in = 1'b0; shift_clock_in = 1'b0; latch_clock_in = 1'b0;
        shift_reg_reset_in = 1'b0; word_ready = 1'b0; clear_errors = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_data", {data_high, data_low}, 32'd0);
        check("rst_count", {10'd0, bit_count, word_count}, 32'd0);
        check("rst_errs", {29'd0, err_short, err_overrun, err_overflow}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            sreg_reset_pulse();
            clear_pulse();
            shift_word(vecs[v].bits, vecs[v].nbits);
            latch_pulse();
            check($sformatf("v%0d_valid", v), {31'd0, word_valid}, 32'd1);
            check($sformatf("v%0d_low", v), {16'd0, data_low}, {16'd0, vecs[v].exp_low});
            check($sformatf("v%0d_high", v), {16'd0, data_high}, {16'd0, vecs[v].exp_high});
            check($sformatf("v%0d_bit_count", v), {26'd0, bit_count}, {26'd0, vecs[v].exp_cnt});
            check($sformatf("v%0d_err_short", v), {31'd0, err_short}, {31'd0, vecs[v].exp_short});
            check($sformatf("v%0d_err_overrun", v), {31'd0, err_overrun},
                  {31'd0, vecs[v].exp_overrun});
            check($sformatf("v%0d_err_overflow", v), {31'd0, err_overflow}, 32'd0);
            accept_word($sformatf("v%0d", v));
            clear_pulse();
            check($sformatf("v%0d_errs_cleared", v),
                  {29'd0, err_short, err_overrun, err_overflow}, 32'd0);
        end

        // Overflow: second word arrives while the first is still unaccepted.
        sreg_reset_pulse();
        shift_word(64'h1234_5678, 32);
        latch_pulse();
        check("ovf_first_valid", {31'd0, word_valid}, 32'd1);
        sreg_reset_pulse();
        shift_word(64'hDEAD_BEEF, 32);
        latch_pulse();
        check("ovf_data_retained", {data_high, data_low}, 32'h1234_5678);
        check("ovf_err_overflow", {31'd0, err_overflow}, 32'd1);
        check("ovf_still_valid", {31'd0, word_valid}, 32'd1);
        accept_word("ovf");
        check("ovf_sticky", {31'd0, err_overflow}, 32'd1);
        clear_pulse();

        // Latch and shift-register reset on the same sampled cycle.
        sreg_reset_pulse();
        shift_word(64'h0BAD_CAFE, 32);
        latch_clock_in = 1'b1;
        shift_reg_reset_in = 1'b1;
        tick(TX_LATCH_HIGH_CYCLES);
        latch_clock_in = 1'b0;
        shift_reg_reset_in = 1'b0;
        tick(TX_LATCH_HIGH_CYCLES);
        check("lr_data", {data_high, data_low}, 32'h0BAD_CAFE);
        check("lr_bit_count", {26'd0, bit_count}, 32'd32);
        check("lr_errs", {29'd0, err_short, err_overrun, err_overflow}, 32'd0);
        accept_word("lr");
        // A single shift from EMPTY must not flag overrun.
        shift_word(64'h1, 1);
        latch_pulse();
        check("one_bit_count", {26'd0, bit_count}, 32'd1);
        check("one_data", {data_high, data_low}, 32'h8000_0000);
        check("one_err_short", {31'd0, err_short}, 32'd1);
        check("one_err_overrun", {31'd0, err_overrun}, 32'd0);

        // Asynchronous reset mid-word while a word is still presented.
        shift_word(64'h3FF, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, word_valid}, 32'd0);
        check("arst_data", {data_high, data_low}, 32'd0);
        check("arst_counts", {10'd0, bit_count, word_count}, 32'd0);
        check("arst_errs", {29'd0, err_short, err_overrun, err_overflow}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        exp_wc = 0;
        tick(2);
        check("arst_no_word", {31'd0, word_valid}, 32'd0);
        shift_word(64'hCAFE_F00D, 32);
        latch_pulse();
        check("post_data", {data_high, data_low}, 32'hCAFE_F00D);
        check("post_bit_count", {26'd0, bit_count}, 32'd32);
        check("post_errs", {29'd0, err_short, err_overrun, err_overflow}, 32'd0);
        accept_word("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
